result_writeback: RTL and testbench



---
 rtl/result_writeback.sv | 141 ++++++++++++++
 tb/tb_result_writeback.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback.sv
// Avalon-MM write initiator: snapshots the result vector on start and writes it back two results per 64-bit word.
// Latency: start sampled at edge 0, writes in cycles 1..NUM_RESULTS/2, done from cycle NUM_RESULTS/2+1 (+1 per stall cycle).
// Backpressure: mm_waitrequest freezes address/data/byteenable; the next word loads only on an accepted transfer.
module result_writeback #(
  parameter logic [31:0] BASE_ADDR    = 32'd9,
  parameter int          NUM_RESULTS  = 8,
  parameter int          RESULT_WIDTH = 24
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [NUM_RESULTS*RESULT_WIDTH-1:0]   c_in,
  output logic [31:0]                           mm_address,
  output logic                                  mm_write,
  output logic [63:0]                           mm_writedata,
  output logic [7:0]                            mm_byteenable,
  input  logic                                  mm_waitrequest,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(NUM_RESULTS/2):0]        words_written
);

  localparam int NW = NUM_RESULTS / 2;
  localparam int RW = RESULT_WIDTH;
  localparam int CW = $clog2(NW) + 1;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_next;

  logic [NUM_RESULTS*RW-1:0]     r_c;
  logic [IW-1:0]                 r_idx;
  logic [CW-1:0]                 r_cnt;
  logic [31:0]                   r_addr;
  logic                          r_write;
  logic [63:0]                   r_data;
  logic [7:0]                    r_be;
  logic                          r_busy;
  logic                          r_done;

  logic                          w_accept;
  logic                          w_launch;
  logic                          w_last;
  logic [IW-1:0]                 w_nidx;
  logic [63:0]                   w_start_word;
  logic [63:0]                   w_words [NW];

  assign w_accept = r_write & ~mm_waitrequest;
  assign w_launch = (r_state != S_WRITE) & start;
  assign w_last   = (r_idx == IW'(NW - 1));
  // Index of the following word; held at 0 on the last word so the lookup never leaves the table.
  assign w_nidx   = w_last ? '0 : (r_idx + IW'(1));

  // Word 0 comes straight from c_in because the shadow copy is loaded on the same edge.
  always_comb begin
    w_start_word            = '0;
    w_start_word[RW-1:0]    = c_in[RW-1:0];
    w_start_word[32 +: RW]  = c_in[RW +: RW];
  end

  // Zero-extended word table built from the snapshot, two results per word.
  always_comb begin
    for (int k = 0; k < NW; k++) begin
      w_words[k]            = '0;
      w_words[k][RW-1:0]    = r_c[(2*k)*RW +: RW];
      w_words[k][32 +: RW]  = r_c[(2*k+1)*RW +: RW];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: start only honoured outside WRITE; WRITE ends on acceptance of the last word.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_WRITE;
      S_WRITE: if (w_accept && w_last) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_WRITE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered bus outputs: launch, advance on accept, finish after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c     <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_addr  <= BASE_ADDR;
      r_write <= 1'b0;
      r_data  <= '0;
      r_be    <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_launch) begin
      r_c     <= c_in;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_addr  <= BASE_ADDR;
      r_write <= 1'b1;
      r_data  <= w_start_word;
      r_be    <= 8'hFF;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if ((r_state == S_WRITE) && w_accept) begin
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_write <= 1'b0;
        r_be    <= 8'h00;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        r_idx   <= w_nidx;
        r_addr  <= r_addr + 32'd1;
        r_data  <= w_words[w_nidx];
      end
    end
  end

  assign mm_address    = r_addr;
  assign mm_write      = r_write;
  assign mm_writedata  = r_data;
  assign mm_byteenable = r_be;
  assign busy          = r_busy;
  assign done          = r_done;
  assign words_written = r_cnt;

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: scoreboard of expected bus writes plus per-scenario timing checks.
// Inputs change 2 time units after the rising edge; the bus monitor samples on the falling edge.
// Every wait is bounded by a cycle budget; an expired budget shows up as a wrong done cycle.
module tb_result_writeback;

  localparam int NR = 8;
  localparam int RW = 24;
  localparam int NW = NR / 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [NR*RW-1:0]  c_in;
  logic [31:0]       mm_address;
  logic              mm_write;
  logic [63:0]       mm_writedata;
  logic [7:0]        mm_byteenable;
  logic              mm_waitrequest;
  logic              busy;
  logic              done;
  logic [2:0]        words_written;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_acc  = 0;
  int unsigned c_arr [NR];

  logic        stall_q = 1'b0;
  logic [31:0] h_addr;
  logic [63:0] h_data;
  logic [7:0]  h_be;

  result_writeback #(
    .BASE_ADDR   (32'd9),
    .NUM_RESULTS (NR),
    .RESULT_WIDTH(RW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .c_in          (c_in),
    .mm_address    (mm_address),
    .mm_write      (mm_write),
    .mm_writedata  (mm_writedata),
    .mm_byteenable (mm_byteenable),
    .mm_waitrequest(mm_waitrequest),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: checks stall stability and pops the scoreboard on every accepted transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (mm_write !== 1'b1 || mm_address !== h_addr || mm_writedata !== h_data || mm_byteenable !== h_be) begin
          errors++;
          $display("FAIL stall_hold: got wr=%0b addr=%0h data=%h be=%h, required wr=1 addr=%0h data=%h be=%h",
                   mm_write, mm_address, mm_writedata, mm_byteenable, h_addr, h_data, h_be);
        end
      end
      stall_q = mm_write && mm_waitrequest;
      if (stall_q) begin
        h_addr = mm_address;
        h_data = mm_writedata;
        h_be   = mm_byteenable;
      end
      if (mm_write && !mm_waitrequest) begin
        exp_t e;
        n_acc++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0h data=%h, required no write", mm_address, mm_writedata);
        end else begin
          e = exp_q.pop_front();
          if (mm_address !== e.addr || mm_writedata !== e.data || mm_byteenable !== 8'hFF) begin
            errors++;
            $display("FAIL write_word: got addr=%0h data=%h be=%h, required addr=%0h data=%h be=ff",
                     mm_address, mm_writedata, mm_byteenable, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive c_in from c_arr, queue the expected words and pulse start for one edge.
  task automatic do_start();
    exp_t e;
    for (int k = 0; k < NR; k++) c_in[k*RW +: RW] = c_arr[k][RW-1:0];
    for (int i = 0; i < NW; i++) begin
      e.addr = 32'd9 + i;
      e.data = {8'h00, c_arr[2*i+1][RW-1:0], 8'h00, c_arr[2*i][RW-1:0]};
      exp_q.push_back(e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives waitrequest (and optional mid-run disturbance) until done; reports done cycle and mm_write cycles.
  task automatic run_until_done(input int stall_addr, input int stall_len, input bit perturb,
                                output int done_cyc, output int wr_cyc);
    int stalled = 0;
    done_cyc = 0;
    wr_cyc   = 0;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        done_cyc = n;
        break;
      end
      mm_waitrequest = 1'b0;
      if (mm_write && mm_address == stall_addr && stalled < stall_len) begin
        mm_waitrequest = 1'b1;
        stalled++;
      end
      if (perturb && n == 2) begin
        c_in  = ~c_in;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (mm_write) wr_cyc++;
      tick();
    end
    mm_waitrequest = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    mm_waitrequest = 1'b0;
    c_in = '0;
    tick();
    tick();
    checks++;
    if (mm_address !== 32'd9 || mm_write !== 1'b0 || mm_writedata !== 64'd0 || mm_byteenable !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: got addr=%0h wr=%0b data=%h be=%h, required 9/0/0/00",
               mm_address, mm_write, mm_writedata, mm_byteenable);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || words_written !== 3'd0) begin
      errors++;
      $display("FAIL reset_status: got busy=%0b done=%0b ww=%0d, required 0/0/0", busy, done, words_written);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (mm_write !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got wr=%0b done=%0b busy=%0b, required 0/0/0", mm_write, done, busy);
    end
  endtask

  task automatic test_no_stall();
    int dc, wc, a0;
    for (int k = 0; k < NR; k++) c_arr[k] = k + 1;
    a0 = n_acc;
    do_start();
    checks++;
    if (mm_writedata !== 64'h00000002_00000001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL nostall_word0: got data=%h busy=%0b, required 0000000200000001/1", mm_writedata, busy);
    end
    run_until_done(-1, 0, 1'b0, dc, wc);
    checks++;
    if (dc !== 5 || wc !== 4) begin
      errors++;
      $display("FAIL nostall_timing: got done_cycle=%0d write_cycles=%0d, required 5/4", dc, wc);
    end
    checks++;
    if (words_written !== 3'd4 || n_acc - a0 !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL nostall_count: got ww=%0d accepted=%0d pending=%0d, required 4/4/0",
               words_written, n_acc - a0, exp_q.size());
    end
  endtask

  task automatic test_stall();
    int dc, wc;
    for (int k = 0; k < NR; k++) c_arr[k] = 32'h100 * (k + 3) + k;
    do_start();
    run_until_done(10, 3, 1'b0, dc, wc);
    checks++;
    if (dc !== 8 || wc !== 7) begin
      errors++;
      $display("FAIL stall_timing: got done_cycle=%0d write_cycles=%0d, required 8/7", dc, wc);
    end
    checks++;
    if (words_written !== 3'd4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL stall_count: got ww=%0d pending=%0d, required 4/0", words_written, exp_q.size());
    end
  endtask

  task automatic test_snapshot();
    int dc, wc, a0;
    for (int k = 0; k < NR; k++) c_arr[k] = 24'h5A0000 + 24'h1111 * k;
    a0 = n_acc;
    do_start();
    run_until_done(-1, 0, 1'b1, dc, wc);
    checks++;
    if (dc !== 5 || n_acc - a0 !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL snapshot_ignore: got done_cycle=%0d accepted=%0d pending=%0d, required 5/4/0",
               dc, n_acc - a0, exp_q.size());
    end
  endtask

  task automatic test_width();
    int dc, wc;
    for (int k = 0; k < NR; k++) c_arr[k] = 32'h00FFFFFF;
    do_start();
    checks++;
    if (mm_writedata !== 64'h00FFFFFF_00FFFFFF) begin
      errors++;
      $display("FAIL width_word0: got %h, required 00ffffff00ffffff", mm_writedata);
    end
    run_until_done(-1, 0, 1'b0, dc, wc);
    checks++;
    if (dc !== 5 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL width_run: got done_cycle=%0d pending=%0d, required 5/0", dc, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int dc, wc, a0;
    for (int k = 0; k < NR; k++) c_arr[k] = 24'h030000 + k * 7;
    a0 = n_acc;
    do_start();
    tick();
    tick();
    checks++;
    if (n_acc - a0 !== 2 || mm_write !== 1'b1) begin
      errors++;
      $display("FAIL midrun_setup: got accepted=%0d wr=%0b, required 2/1", n_acc - a0, mm_write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mm_write !== 1'b0 || done !== 1'b0 || words_written !== 3'd0 || busy !== 1'b0 || mm_address !== 32'd9) begin
      errors++;
      $display("FAIL midrun_reset: got wr=%0b done=%0b ww=%0d busy=%0b addr=%0h, required 0/0/0/0/9",
               mm_write, done, words_written, busy, mm_address);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    a0 = n_acc;
    do_start();
    checks++;
    if (mm_address !== 32'd9) begin
      errors++;
      $display("FAIL midrun_restart_addr: got %0h, required 9", mm_address);
    end
    run_until_done(-1, 0, 1'b0, dc, wc);
    checks++;
    if (dc !== 5 || n_acc - a0 !== 4 || words_written !== 3'd4) begin
      errors++;
      $display("FAIL midrun_restart: got done_cycle=%0d accepted=%0d ww=%0d, required 5/4/4",
               dc, n_acc - a0, words_written);
    end
  endtask

  task automatic test_restart_from_done();
    int dc, wc;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre_done: got done=%0b, required 1", done);
    end
    for (int k = 0; k < NR; k++) c_arr[k] = 8'hA0 + k;
    do_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || mm_write !== 1'b1) begin
      errors++;
      $display("FAIL restart_drop: got done=%0b busy=%0b wr=%0b, required 0/1/1", done, busy, mm_write);
    end
    run_until_done(-1, 0, 1'b0, dc, wc);
    checks++;
    if (dc !== 5 || wc !== 4 || exp_q.size() !== 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL restart_run: got done_cycle=%0d write_cycles=%0d pending=%0d done=%0b, required 5/4/0/1",
               dc, wc, exp_q.size(), done);
    end
  endtask

  initial begin
    test_reset();
    test_no_stall();
    test_stall();
    test_snapshot();
    test_width();
    test_reset_mid_run();
    test_restart_from_done();
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
